// File: rtl/fifo_uart_tx.sv
// Serial transmitter draining the read side of an 8-bit synchronous FIFO.
// Frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned    TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_d, fifo_rd_d, done_d;
  logic          bit_last;

  assign bit_last = (timer == T_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      tx         <= tx_d;
      fifo_rd    <= fifo_rd_d;
      frame_done <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    fifo_rd_d = 1'b0;
    done_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d   = FETCH;
          fifo_rd_d = 1'b1;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shreg_d = fifo_data;
        timer_d = '0;
        state_d = START;
      end
      START: begin
        if (bit_last) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          timer_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      PARITY: begin
        if (bit_last) begin
          timer_d = '0;
          state_d = STOP;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          timer_d = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx stays a pure register output.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bit_idx_d];
      PARITY:  tx_d = ^shreg_d;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity (4 clk/bit),
// one with even parity (2 clk/bit), each fed by a small behavioural FIFO.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en_a = 1'b0, en_b = 1'b0;
  logic       use_rand = 1'b0, rand_fe = 1'b1;
  logic [7:0] mem_a [0:63];
  logic [7:0] mem_b [0:63];
  int         wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  logic [7:0] dat_a = '0, dat_b = '0;
  logic       fe_a, fe_b;
  logic       rd_a_o, tx_a, busy_a, done_a;
  logic       rd_b_o, tx_b, busy_b, done_b;

  assign fe_a = use_rand ? rand_fe : (wr_a == rd_a);
  assign fe_b = use_rand ? rand_fe : (wr_b == rd_b);

  always @(posedge clk) begin
    if (rd_a_o) begin
      dat_a <= mem_a[rd_a[5:0]];
      rd_a  <= rd_a + 1;
    end
    if (rd_b_o) begin
      dat_b <= mem_b[rd_b[5:0]];
      rd_b  <= rd_b + 1;
    end
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .fifo_empty(fe_a), .fifo_data(dat_a),
    .fifo_rd(rd_a_o), .tx(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .fifo_empty(fe_b), .fifo_data(dat_b),
    .fifo_rd(rd_b_o), .tx(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel != 0) begin
      mem_b[wr_b[5:0]] = d;
      wr_b = wr_b + 1;
    end else begin
      mem_a[wr_a[5:0]] = d;
      wr_a = wr_a + 1;
    end
  endtask

  task automatic set_en(input int sel, input logic v);
    if (sel != 0) en_b = v;
    else en_a = v;
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction
  function automatic logic rd_of(input int sel);
    return (sel != 0) ? rd_b_o : rd_a_o;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction

  // Called at a negedge; seq[i] is the expected line level of bit slot i.
  task automatic frame_check(input int sel, input logic [7:0] d, input bit do_push,
                             input int nbits, input logic [10:0] seq,
                             input int drop_idx, input string nm);
    int  cpb;
    int  n;
    bit  ok;
    cpb = (sel != 0) ? 2 : 4;
    if (do_push) push(sel, d);
    set_en(sel, 1'b1);
    n = 0;
    while (!rd_of(sel) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_rd_seen"}, rd_of(sel), 1);
    if (!rd_of(sel)) begin
      set_en(sel, 1'b0);
      return;
    end
    chk({nm, "_busy_fetch"}, busy_of(sel), 1);
    chk({nm, "_tx_fetch"}, tx_of(sel), 1);
    @(negedge clk);
    chk({nm, "_rd_one_cycle"}, rd_of(sel), 0);
    chk({nm, "_tx_load"}, tx_of(sel), 1);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ok = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        if (tx_of(sel) !== seq[i] || busy_of(sel) !== 1'b1 ||
            rd_of(sel) !== 1'b0 || done_of(sel) !== 1'b0) ok = 1'b0;
        if (i == drop_idx && c == 1) set_en(sel, 1'b0);
        @(negedge clk);
      end
      chk($sformatf("%s_slot%0d_ok", nm, i), ok, 1);
    end
    chk({nm, "_done_pulse"}, done_of(sel), 1);
    chk({nm, "_busy_end"}, busy_of(sel), 0);
    chk({nm, "_tx_end"}, tx_of(sel), 1);
    set_en(sel, 1'b0);
    @(negedge clk);
    chk({nm, "_done_single"}, done_of(sel), 0);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         nbits;
    logic [10:0] seq;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         n;
    int         rd_cnt;
    int         rd2;
    int         run;
    int         k;
    logic       tr [0:119];
    logic       rr [0:119];
    logic       fe_snap;

    // {unused/stop, stop/parity, data[7:0], start}: slot i is seq[i]
    vecs[0] = '{0, 8'hA5, 10, 11'b0_1_10100101_0};
    vecs[1] = '{0, 8'h00, 10, 11'b0_1_00000000_0};
    vecs[2] = '{0, 8'hFF, 10, 11'b0_1_11111111_0};
    vecs[3] = '{0, 8'h3C, 10, 11'b0_1_00111100_0};
    vecs[4] = '{1, 8'h07, 11, 11'b1_1_00000111_0};
    vecs[5] = '{1, 8'h03, 11, 11'b1_0_00000011_0};
    vecs[6] = '{1, 8'h80, 11, 11'b1_1_10000000_0};

    // Reset held with random inputs
    use_rand = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      en_a = 1'($urandom);
      en_b = 1'($urandom);
      rand_fe = 1'($urandom);
      @(negedge clk);
      if (tx_a !== 1'b1 || rd_a_o !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
          tx_b !== 1'b1 || rd_b_o !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) ok = 1'b0;
    end
    chk("reset_hold_outputs", ok, 1);
    use_rand = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    rst = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || rd_a_o !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
          tx_b !== 1'b1 || rd_b_o !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) ok = 1'b0;
    end
    chk("reset_release_idle", ok, 1);

    // Single-frame vectors
    for (int v = 0; v < 7; v++) begin
      frame_check(vecs[v].sel, vecs[v].data, 1'b1, vecs[v].nbits, vecs[v].seq, -1,
                  $sformatf("vec%0d", v));
      @(negedge clk);
    end

    // Back-to-back 0x00 then 0xFF
    push(0, 8'h00);
    push(0, 8'hFF);
    en_a = 1'b1;
    n = 0;
    while (!rd_a_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    fe_snap = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tr[i] = tx_a;
      rr[i] = rd_a_o;
      if (i == 50) fe_snap = fe_a;
      @(negedge clk);
    end
    en_a = 1'b0;
    rd_cnt = 0;
    rd2 = -1;
    ok = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (rr[i]) begin
        rd_cnt++;
        if (i > 0 && rd2 < 0) rd2 = i;
        if (i > 0 && rr[i-1]) ok = 1'b0;
      end
    end
    chk("b2b_rd_first", rr[0], 1);
    chk("b2b_rd_count", rd_cnt, 2);
    chk("b2b_rd_pitch", rd2, 43);
    chk("b2b_rd_not_consecutive", ok, 1);
    chk("b2b_empty_after_pop", fe_snap, 1);
    k = 2;
    while (k < 119 && tr[k] !== 1'b1) k++;
    run = 0;
    while (k < 119 && tr[k] === 1'b1) begin
      run++;
      k++;
    end
    chk("b2b_gap_high_cycles", run, 7);
    chk("b2b_frame2_start", tr[45], 0);
    chk("b2b_frame2_data0", tr[49], 1);
    @(negedge clk);

    // Enable gating
    push(0, 8'h3C);
    en_a = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_a_o !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) ok = 1'b0;
    end
    chk("gate_disabled_idle", ok, 1);
    push(0, 8'h00);
    frame_check(0, 8'h3C, 1'b0, 10, 11'b0_1_00111100_0, 4, "gate");
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_a_o !== 1'b0 || busy_a !== 1'b0) ok = 1'b0;
    end
    chk("gate_no_refetch", ok, 1);
    chk("gate_fifo_still_full", fe_a, 0);

    // Reset during data bit 5 of byte 0x00, then resume with 0xA5
    push(0, 8'hA5);
    en_a = 1'b1;
    n = 0;
    while (!rd_a_o && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_rd_seen", rd_a_o, 1);
    repeat (27) @(negedge clk);
    chk("rstmid_tx_low_before", tx_a, 0);
    chk("rstmid_busy_before", busy_a, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_tx_async", tx_a, 1);
    chk("rstmid_busy_async", busy_a, 0);
    chk("rstmid_rd_async", rd_a_o, 0);
    chk("rstmid_done_async", done_a, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_tx_held", tx_a, 1);
    rst = 1'b1;
    frame_check(0, 8'hA5, 1'b0, 10, 11'b0_1_10100101_0, -1, "rstmid_next");
    chk("rstmid_fifo_drained", fe_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
